// File: rtl/ex_issue_stage_if.sv
// ex_issue_stage_if: decode, forwarding and execute signals of the issue stage
interface ex_issue_stage_if #(parameter int DW = 32, parameter int RW = 5);
  logic flush_i;
  logic dec_valid_i;
  logic dec_ready_o;
  logic [14:0] dec_ctrl_i;
  logic [RW-1:0] dec_rs1_i;
  logic [RW-1:0] dec_rs2_i;
  logic [DW-1:0] dec_rs1_data_i;
  logic [DW-1:0] dec_rs2_data_i;
  logic [DW-1:0] dec_pc_i;
  logic [DW-1:0] dec_imm_i;
  logic dec_use_pc_i;
  logic dec_use_imm_i;
  logic [RW-1:0] dec_rd_i;
  logic dec_rd_we_i;
  logic mem_fwd_we_i;
  logic [RW-1:0] mem_fwd_rd_i;
  logic [DW-1:0] mem_fwd_data_i;
  logic mem_fwd_pend_i;
  logic wb_fwd_we_i;
  logic [RW-1:0] wb_fwd_rd_i;
  logic [DW-1:0] wb_fwd_data_i;
  logic ex_valid_o;
  logic ex_ready_i;
  logic [14:0] ex_ctrl_o;
  logic [DW-1:0] ex_data0_o;
  logic [DW-1:0] ex_data1_o;
  logic [DW-1:0] ex_cmp_data0_o;
  logic [DW-1:0] ex_cmp_data1_o;
  logic [RW-1:0] ex_rd_o;
  logic ex_rd_we_o;
  modport master (
    output flush_i, dec_valid_i, dec_ctrl_i, dec_rs1_i, dec_rs2_i, dec_rs1_data_i, dec_rs2_data_i,
           dec_pc_i, dec_imm_i, dec_use_pc_i, dec_use_imm_i, dec_rd_i, dec_rd_we_i,
           mem_fwd_we_i, mem_fwd_rd_i, mem_fwd_data_i, mem_fwd_pend_i,
           wb_fwd_we_i, wb_fwd_rd_i, wb_fwd_data_i, ex_ready_i,
    input  dec_ready_o, ex_valid_o, ex_ctrl_o, ex_data0_o, ex_data1_o,
           ex_cmp_data0_o, ex_cmp_data1_o, ex_rd_o, ex_rd_we_o
  );
  modport slave (
    input  flush_i, dec_valid_i, dec_ctrl_i, dec_rs1_i, dec_rs2_i, dec_rs1_data_i, dec_rs2_data_i,
           dec_pc_i, dec_imm_i, dec_use_pc_i, dec_use_imm_i, dec_rd_i, dec_rd_we_i,
           mem_fwd_we_i, mem_fwd_rd_i, mem_fwd_data_i, mem_fwd_pend_i,
           wb_fwd_we_i, wb_fwd_rd_i, wb_fwd_data_i, ex_ready_i,
    output dec_ready_o, ex_valid_o, ex_ctrl_o, ex_data0_o, ex_data1_o,
           ex_cmp_data0_o, ex_cmp_data1_o, ex_rd_o, ex_rd_we_o
  );
endinterface

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: decode-to-execute register with forwarding, load-use stall and flush; ISSUE_PERF_EN adds issue/stall counters
module ex_issue_stage #(parameter int DW = 32, parameter int RW = 5) (
  input logic clk_i,
  input logic reset_i,
  ex_issue_stage_if.slave bus
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issue_o,
  output logic [31:0] perf_stall_o
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [14:0] ctrl_q, ctrl_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d, cmp0_q, cmp0_d, cmp1_q, cmp1_d;
  logic [RW-1:0] rd_q, rd_d;
  logic rd_we_q, rd_we_d;
  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2, hz, free, accept;
  logic [DW-1:0] fwd1, fwd2;
  // forwarding (MEM over WB, x0 reads zero), load-use hazard and decode handshake
  always_comb begin
    mem_hit1 = bus.dec_rs1_i != '0 && bus.mem_fwd_we_i && bus.mem_fwd_rd_i == bus.dec_rs1_i;
    mem_hit2 = bus.dec_rs2_i != '0 && bus.mem_fwd_we_i && bus.mem_fwd_rd_i == bus.dec_rs2_i;
    wb_hit1 = bus.wb_fwd_we_i && bus.wb_fwd_rd_i == bus.dec_rs1_i;
    wb_hit2 = bus.wb_fwd_we_i && bus.wb_fwd_rd_i == bus.dec_rs2_i;
    fwd1 = bus.dec_rs1_i == '0 ? '0 : mem_hit1 ? bus.mem_fwd_data_i : wb_hit1 ? bus.wb_fwd_data_i : bus.dec_rs1_data_i;
    fwd2 = bus.dec_rs2_i == '0 ? '0 : mem_hit2 ? bus.mem_fwd_data_i : wb_hit2 ? bus.wb_fwd_data_i : bus.dec_rs2_data_i;
    hz = bus.dec_valid_i && (mem_hit1 || mem_hit2) && bus.mem_fwd_pend_i;
    free = state_q == EMPTY || bus.ex_ready_i;
    bus.dec_ready_o = !reset_i && (bus.flush_i || (free && !hz));
    accept = bus.dec_valid_i && bus.dec_ready_o && !bus.flush_i;
  end
  // next state: flush kills, accept captures, a free slot without accept becomes a bubble, otherwise hold
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    data0_d = data0_q;
    data1_d = data1_q;
    cmp0_d = cmp0_q;
    cmp1_d = cmp1_q;
    rd_d = rd_q;
    rd_we_d = rd_we_q;
    if (bus.flush_i || (free && !accept)) begin
      state_d = EMPTY;
      ctrl_d = '0;
      rd_we_d = 1'b0;
    end else if (accept) begin
      state_d = FULL;
      ctrl_d = bus.dec_ctrl_i;
      data0_d = bus.dec_use_pc_i ? bus.dec_pc_i : fwd1;
      data1_d = bus.dec_use_imm_i ? bus.dec_imm_i : fwd2;
      cmp0_d = fwd1;
      cmp1_d = fwd2;
      rd_d = bus.dec_rd_i;
      rd_we_d = bus.dec_rd_we_i;
    end
  end
  // pipeline register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      ctrl_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      cmp0_q <= '0;
      cmp1_q <= '0;
      rd_q <= '0;
      rd_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cmp0_q <= cmp0_d;
      cmp1_q <= cmp1_d;
      rd_q <= rd_d;
      rd_we_q <= rd_we_d;
    end
  end
  assign bus.ex_valid_o = state_q == FULL;
  assign bus.ex_ctrl_o = ctrl_q;
  assign bus.ex_data0_o = data0_q;
  assign bus.ex_data1_o = data1_q;
  assign bus.ex_cmp_data0_o = cmp0_q;
  assign bus.ex_cmp_data1_o = cmp1_q;
  assign bus.ex_rd_o = rd_q;
  assign bus.ex_rd_we_o = rd_we_q;
`ifdef ISSUE_PERF_EN
  logic [31:0] issue_q, issue_d, stall_q, stall_d;
  // issue and stall counters, wrapping, untouched by flush
  always_comb begin
    issue_d = issue_q + 32'(accept);
    stall_d = stall_q + 32'(hz && !bus.flush_i);
  end
  // counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      issue_q <= issue_d;
      stall_q <= stall_d;
    end
  end
  assign perf_issue_o = issue_q;
  assign perf_stall_o = stall_q;
`endif
endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
Decode-to-execute pipeline register sitting directly upstream of the ALU.
- Resolves operand forwarding from the MEM and WB stages.
- Selects the ALU operands (register/PC/immediate) and the comparator operands.
- Registers the ALU control bundle and the destination fields.
- Uses a valid/ready handshake on both sides, with load-use stall and flush handling.

Parameters:
DW, 32, data width in bits of operands, PC and immediate
RW, 5, register address width

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  kill the held instruction and the current decode handshake
dec_valid_i  in  1  decode presents an instruction
dec_ready_o  out  1  stage accepts the decode instruction this cycle
dec_ctrl_i  in  15  {adder_op[14:13], compare_op[12:7], shift_op[6:4], sub_en[3], xor_en[2], or_en[1], and_en[0]}
dec_rs1_i  in  RW  source 1 address
dec_rs2_i  in  RW  source 2 address
dec_rs1_data_i  in  DW  register-file read data 1
dec_rs2_data_i  in  DW  register-file read data 2
dec_pc_i  in  DW  instruction PC
dec_imm_i  in  DW  sign-extended immediate
dec_use_pc_i  in  1  data0 = PC instead of rs1
dec_use_imm_i  in  1  data1 = immediate instead of rs2
dec_rd_i  in  RW  destination address
dec_rd_we_i  in  1  destination write enable
mem_fwd_we_i  in  1  MEM-stage instruction writes rd
mem_fwd_rd_i  in  RW  MEM-stage rd
mem_fwd_data_i  in  DW  MEM-stage result
mem_fwd_pend_i  in  1  MEM-stage result not yet available (load)
wb_fwd_we_i  in  1  WB-stage instruction writes rd
wb_fwd_rd_i  in  RW  WB-stage rd
wb_fwd_data_i  in  DW  WB-stage result
ex_valid_o  out  1  registered instruction valid toward the ALU
ex_ready_i  in  1  execute consumes the instruction this cycle
ex_ctrl_o  out  15  registered control bundle, same bit layout as dec_ctrl_i
ex_data0_o  out  DW  ALU data0
ex_data1_o  out  DW  ALU data1
ex_cmp_data0_o  out  DW  comparator operand 0 (forwarded rs1)
ex_cmp_data1_o  out  DW  comparator operand 1 (forwarded rs2)
ex_rd_o  out  RW  registered rd
ex_rd_we_o  out  1  registered rd write enable

Behaviour:
- Reset: all outputs registered to 0. dec_ready_o = 0 during the reset cycle.
- Forwarding, per source s in {rs1, rs2}:
  - s == 0 -> 0.
  - Else MEM match (mem_fwd_we_i && mem_fwd_rd_i == s) -> mem_fwd_data_i.
  - Else WB match -> wb_fwd_data_i.
  - Else register-file data. MEM has priority over WB.
- Hazard: hz = dec_valid_i && the MEM match on rs1 or rs2 (nonzero address) && mem_fwd_pend_i. A source selected away by use_pc/use_imm still counts (comparator uses it).
- Operand select:
  - data0 = use_pc ? pc : fwd_rs1.
  - data1 = use_imm ? imm : fwd_rs2.
  - cmp0 = fwd_rs1, cmp1 = fwd_rs2.
- Handshake:
  - free = !ex_valid_o || ex_ready_i.
  - dec_ready_o = free && !hz && !reset_i (combinational).
  - Accept = dec_valid_i && dec_ready_o: capture all fields next edge, ex_valid_o = 1.
  - free && !accept: ex_valid_o -> 0 (bubble). During a bubble, ex_ctrl_o and ex_rd_we_o are cleared so the ALU result is 0 and nothing writes back.
  - Held (ex_valid_o && !ex_ready_i): all outputs stable, no re-forwarding.
- Latency: 1 cycle decode -> execute. Full throughput when there is no hazard and ex_ready_i = 1.
- State machine (two states):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on consume+accept.
  - FULL -> EMPTY on consume without accept.
  - FULL holds while !ex_ready_i.
- flush_i (highest priority after reset):
  - Next state EMPTY, ex_valid_o / ex_ctrl_o / ex_rd_we_o = 0.
  - dec_ready_o = 1 in the flush cycle (decode instruction discarded, not captured).
- Reset asserted mid-stall: state -> EMPTY, stall condition cleared.

Optional Feature:
ISSUE_PERF_EN
- Defined: adds outputs perf_issue_o [31:0] and perf_stall_o [31:0], both reset to 0.
  - perf_issue_o increments on each accept.
  - perf_stall_o increments each cycle dec_valid_i && hz && !flush_i.
  - Both wrap modulo 2^32 and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Back-to-back: decode ADD rs1 = 1 (0x10), rs2 = 2 (0x20), ex_ready_i = 1 for 4 instructions -> ex_valid_o high 4 consecutive cycles, each one cycle after its accept; data0 = 0x10, data1 = 0x20.
- Forwarding priority: MEM rd = 3 data 0xAAAA and WB rd = 3 data 0xBBBB; decode rs1 = 3 -> ex_data0_o = 0xAAAA. With MEM we = 0 -> 0xBBBB. With rs1 = 0 and MEM rd = 0 -> 0.
- Load-use: mem_fwd_pend_i = 1 with MEM rd = 5; decode rs2 = 5 with use_imm = 1 -> dec_ready_o = 0 and a bubble (ex_ctrl_o = 0, ex_rd_we_o = 0). When pend drops -> accept with cmp1 = mem data.
- Backpressure: ex_ready_i = 0 for 3 cycles with an instruction held -> outputs unchanged, dec_ready_o = 0. Release -> next instruction captured in the same cycle as the consume.
- Flush: flush_i while FULL and held, with dec_valid_i = 1 -> next cycle ex_valid_o = 0 and the decode instruction is not issued.
- Reset: assert reset_i with valid data pending -> all outputs 0 next cycle, dec_ready_o = 0 during reset. With ISSUE_PERF_EN: 4 issues + 2 stall cycles -> perf_issue_o = 4, perf_stall_o = 2.
